// File: rtl/dm_dump_streamer.sv
// Drains a block of DM words onto a valid/ready byte stream, MSB first.
// Optional trailing 32-bit sum of the dumped words when DUMP_CHECKSUM_EN is defined.
module dm_dump_streamer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SEND,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MaxCnt = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [1:0]        idx_q, idx_d;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      shreg_q  <= '0;
      idx_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          // Counts beyond the DM depth would only re-read wrapped words.
          remain_d = (word_cnt > MaxCnt) ? MaxCnt : word_cnt;
`ifdef DUMP_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = (word_cnt == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d  = mem_rdata;
        idx_d    = '0;
        remain_d = remain_q - (ADDR_W + 1)'(1);
`ifdef DUMP_CHECKSUM_EN
        csum_d   = csum_q + mem_rdata;
`endif
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
            if (remain_q != '0) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_READ;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              shreg_d = csum_q;
              idx_d   = '0;
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            shreg_d = {shreg_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            shreg_d = {shreg_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd   = (state_q == S_READ);
  assign mem_addr = addr_q;
  assign tx_data  = shreg_q[31:24];
`ifdef DUMP_CHECKSUM_EN
  assign tx_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
  assign tx_valid = (state_q == S_SEND);
`endif
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule
